mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 43 ++++
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg / mem_stage_if                                                   |
// | Execute-to-memory parameter bundle and data-bus request/grant/response   |
// | interface for the MINA2000 memory stage.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package mem_pkg;
  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [1:0]  mem_op;
    logic [31:0] mem_data;
    logic [31:0] rd_data;
  } mem_params_t;
endpackage

interface mem_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        dbus_err;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata,
    input  dbus_gnt, dbus_rvalid, dbus_rdata, dbus_err
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
    output dbus_gnt, dbus_rvalid, dbus_rdata, dbus_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage                                                                |
// | MINA2000 memory-access stage: word loads/stores over a req/gnt/rvalid    |
// | bus, registered write-back and fault reporting. Optional bus watchdog    |
// | enabled by defining MEM_TIMEOUT_EN.                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  mem_pkg::mem_params_t mem_params,
  output logic                 in_ready,
  mem_stage_if.master          dbus,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_rd_addr,
  output logic [31:0]          wb_rd_data,
  output logic                 fault,
  output logic [31:0]          fault_addr
);
  import mem_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [4:0]  r_rd_addr;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_accept_mem;
  logic        w_expire;
  logic        w_req;

  logic        w_wb_valid_d;
  logic        w_wb_we_d;
  logic [4:0]  w_wb_rd_addr_d;
  logic [31:0] w_wb_rd_data_d;
  logic        w_fault_d;
  logic [31:0] w_fault_addr_d;

  assign in_ready     = (r_state == S_IDLE);
  assign w_accept     = in_valid && in_ready;
  assign w_is_mem     = (mem_params.mem_op == MEM_OP_LOAD) || (mem_params.mem_op == MEM_OP_STORE);
  assign w_misaligned = (mem_params.rd_data[1:0] != 2'b00);
  assign w_accept_mem = w_accept && w_is_mem && !w_misaligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;

  // Count is zero on the first REQ cycle and advances through REQ and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept_mem) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_expire = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic [31:0] w_timeout_unused;
  assign w_timeout_unused = 32'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_mem) w_next_state = S_REQ;
      end
      S_REQ: begin
        if (w_expire)           w_next_state = S_IDLE;
        else if (dbus.dbus_gnt) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (dbus.dbus_rvalid || w_expire) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_req          = 1'b0;
    w_wb_valid_d   = 1'b0;
    w_wb_we_d      = 1'b0;
    w_wb_rd_addr_d = 5'd0;
    w_wb_rd_data_d = 32'd0;
    w_fault_d      = 1'b0;
    w_fault_addr_d = fault_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_is_mem) begin
          w_wb_valid_d   = 1'b1;
          w_wb_we_d      = 1'b1;
          w_wb_rd_addr_d = mem_params.rd_addr;
          w_wb_rd_data_d = mem_params.rd_data;
        end else if (w_accept && w_misaligned) begin
          w_wb_valid_d   = 1'b1;
          w_wb_rd_addr_d = mem_params.rd_addr;
          w_fault_d      = 1'b1;
          w_fault_addr_d = mem_params.rd_data;
        end
      end
      S_REQ: begin
        w_req = !w_expire;
        if (w_expire) begin
          w_wb_valid_d   = 1'b1;
          w_wb_rd_addr_d = r_rd_addr;
          w_fault_d      = 1'b1;
          w_fault_addr_d = r_addr;
        end
      end
      S_RESP: begin
        // A response in the expiry cycle completes normally.
        if (dbus.dbus_rvalid) begin
          w_wb_valid_d   = 1'b1;
          w_wb_rd_addr_d = r_rd_addr;
          if (dbus.dbus_err) begin
            w_fault_d      = 1'b1;
            w_fault_addr_d = r_addr;
          end else if (!r_we) begin
            w_wb_we_d      = 1'b1;
            w_wb_rd_data_d = dbus.dbus_rdata;
          end
        end else if (w_expire) begin
          w_wb_valid_d   = 1'b1;
          w_wb_rd_addr_d = r_rd_addr;
          w_fault_d      = 1'b1;
          w_fault_addr_d = r_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
      r_rd_addr  <= 5'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd_addr <= 5'd0;
      wb_rd_data <= 32'd0;
      fault      <= 1'b0;
      fault_addr <= 32'd0;
    end else begin
      if (w_accept_mem) begin
        r_addr    <= {mem_params.rd_data[31:2], 2'b00};
        r_wdata   <= mem_params.mem_data;
        r_we      <= (mem_params.mem_op == MEM_OP_STORE);
        r_rd_addr <= mem_params.rd_addr;
      end
      wb_valid   <= w_wb_valid_d;
      wb_we      <= w_wb_we_d;
      wb_rd_addr <= w_wb_rd_addr_d;
      wb_rd_data <= w_wb_rd_data_d;
      fault      <= w_fault_d;
      fault_addr <= w_fault_addr_d;
    end
  end

  assign dbus.dbus_req   = w_req;
  assign dbus.dbus_we    = r_we;
  assign dbus.dbus_addr  = r_addr;
  assign dbus.dbus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage                                                             |
// | Self-checking bench: vector table, random transactions against a         |
// | transaction-level model, and hand-written reset/throughput/timeout runs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_mem_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  mem_params_t params;
  logic        in_ready;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        fault;
  logic [31:0] fault_addr;

  mem_stage_if bus ();

`ifdef MEM_TIMEOUT_EN
  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_stage dut (
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mem_params (params),
    .in_ready   (in_ready),
    .dbus       (bus.master),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_fault_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          gw;
    int          rw;
    logic        err;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_fault;
    int          e_lat;
  } vec_t;

  vec_t vt[8];

  // Transaction-level reference: result and latency follow directly from the op,
  // alignment and the number of bus wait cycles.
  task automatic model(input logic [1:0] op, input logic [31:0] addr, input int gw, input int rw,
                       input logic err, input logic [31:0] rdata,
                       output logic e_we, output logic [31:0] e_data, output logic e_fault, output int e_lat);
    e_we = 0; e_data = 0; e_fault = 0; e_lat = 1;
    if (op != MEM_OP_LOAD && op != MEM_OP_STORE) begin
      e_we = 1; e_data = addr;
    end else if (addr % 4 != 0) begin
      e_fault = 1;
    end else begin
      e_lat = 3 + gw + rw;
      if (err) e_fault = 1;
      else if (op == MEM_OP_LOAD) begin
        e_we = 1; e_data = rdata;
      end
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int   req_n, resp_n, lat;
    logic granted, seen_req, stable_ok, busy_ok, done, is_mem;
    req_n = 0; resp_n = 0; lat = -1;
    granted = 0; seen_req = 0; stable_ok = 1; busy_ok = 1; done = 0;
    is_mem = (v.op == MEM_OP_LOAD || v.op == MEM_OP_STORE) && (v.addr[1:0] == 2'b00);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1;
    params   = '{rd_addr: v.rd, mem_op: v.op, mem_data: v.wd, rd_data: v.addr};
    bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_err = 0;
    for (int k = 1; k <= 64 && !done; k++) begin
      @(posedge clk); #1;
      in_valid = 0;
      bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_err = 0; bus.dbus_rdata = $urandom;
      if (wb_valid) begin
        done = 1; lat = k;
      end else begin
        if (in_ready || wb_we || wb_rd_addr != 0 || wb_rd_data != 0 || fault) busy_ok = 0;
        if (bus.dbus_req) begin
          seen_req = 1;
          if (bus.dbus_addr != v.addr || bus.dbus_we != (v.op == MEM_OP_STORE) ||
              (v.op == MEM_OP_STORE && bus.dbus_wdata != v.wd)) stable_ok = 0;
          if (req_n == v.gw) begin
            bus.dbus_gnt = 1; granted = 1;
          end else if ($urandom_range(1, 0) == 1) begin
            bus.dbus_rvalid = 1; bus.dbus_err = 1'($urandom_range(1, 0));
          end
          req_n++;
        end else if (granted) begin
          if (resp_n == v.rw) begin
            bus.dbus_rvalid = 1; bus.dbus_err = v.err; bus.dbus_rdata = v.rdata;
          end else begin
            bus.dbus_gnt = 1'($urandom_range(1, 0));
          end
          resp_n++;
        end
      end
    end
    bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_err = 0;
    if (v.e_fault) exp_fault_addr = v.addr;
    check({tag, ".lat"}, 32'(lat), 32'(v.e_lat));
    check({tag, ".wb_we"}, 32'(wb_we), 32'(v.e_we));
    if (v.e_we) begin
      check({tag, ".wb_rd_data"}, wb_rd_data, v.e_data);
      check({tag, ".wb_rd_addr"}, 32'(wb_rd_addr), 32'(v.rd));
    end
    check({tag, ".fault"}, 32'(fault), 32'(v.e_fault));
    check({tag, ".fault_addr"}, fault_addr, exp_fault_addr);
    check({tag, ".ready_at_wb"}, 32'(in_ready), 32'd1);
    check({tag, ".req_at_wb"}, 32'(bus.dbus_req), 32'd0);
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    if (is_mem) check({tag, ".bus_stable"}, 32'(seen_req && stable_ok), 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 0;
    params = '0;
    bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_err = 0; bus.dbus_rdata = 0;
    rst_n = 0;
    exp_fault_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    vec_t v;
    int   gmax;
    do_reset();
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.outs", {26'd0, bus.dbus_req, bus.dbus_we, wb_valid, wb_we, fault, 1'b0}, 32'd0);
    check("reset.fault_addr", fault_addr, 32'd0);
    check("reset.dbus_addr", bus.dbus_addr, 32'd0);

    vt[0] = '{op: MEM_OP_NONE,  addr: 32'h1234, wd: 0, rd: 5'd3, gw: 0, rw: 0, err: 0, rdata: 0,
              e_we: 1, e_data: 32'h1234, e_fault: 0, e_lat: 1};
    vt[1] = '{op: MEM_OP_LOAD,  addr: 32'h100, wd: 0, rd: 5'd5, gw: 2, rw: 1, err: 0, rdata: 32'hDEADBEEF,
              e_we: 1, e_data: 32'hDEADBEEF, e_fault: 0, e_lat: 6};
    vt[2] = '{op: MEM_OP_STORE, addr: 32'h200, wd: 32'hCAFEF00D, rd: 5'd0, gw: 0, rw: 0, err: 0, rdata: 0,
              e_we: 0, e_data: 0, e_fault: 0, e_lat: 3};
    vt[3] = '{op: MEM_OP_LOAD,  addr: 32'h103, wd: 0, rd: 5'd7, gw: 0, rw: 0, err: 0, rdata: 0,
              e_we: 0, e_data: 0, e_fault: 1, e_lat: 1};
    vt[4] = '{op: MEM_OP_NONE,  addr: 32'h55, wd: 0, rd: 5'd9, gw: 0, rw: 0, err: 0, rdata: 0,
              e_we: 1, e_data: 32'h55, e_fault: 0, e_lat: 1};
    vt[5] = '{op: MEM_OP_LOAD,  addr: 32'h300, wd: 0, rd: 5'd4, gw: 1, rw: 0, err: 1, rdata: 32'h1111,
              e_we: 0, e_data: 0, e_fault: 1, e_lat: 4};
    vt[6] = '{op: MEM_OP_STORE, addr: 32'h202, wd: 32'h77, rd: 5'd1, gw: 0, rw: 0, err: 0, rdata: 0,
              e_we: 0, e_data: 0, e_fault: 1, e_lat: 1};
    vt[7] = '{op: MEM_OP_LOAD,  addr: 32'h10, wd: 0, rd: 5'd31, gw: 0, rw: 2, err: 0, rdata: 32'h0,
              e_we: 1, e_data: 32'h0, e_fault: 0, e_lat: 5};
    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vt[i]);

    // wb_valid is a single-cycle pulse; a stray response in IDLE changes nothing.
    bus.dbus_rvalid = 1; bus.dbus_err = 1;
    @(posedge clk); #1;
    bus.dbus_rvalid = 0; bus.dbus_err = 0;
    check("idle.wb_valid", 32'(wb_valid), 32'd0);
    check("idle.fault", 32'(fault), 32'd0);
    check("idle.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back NONE instructions at full rate.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      params = '{rd_addr: 5'(i + 10), mem_op: MEM_OP_NONE, mem_data: 0, rd_data: 32'hA000 + 32'(i)};
      @(posedge clk); #1;
      check($sformatf("tput%0d.wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("tput%0d.data", i), wb_rd_data, 32'hA000 + 32'(i));
    end
    in_valid = 0;

`ifdef MEM_TIMEOUT_EN
    gmax = 1;
`else
    gmax = 3;
`endif
    for (int i = 0; i < 40; i++) begin
      v.op    = 2'($urandom_range(2, 0));
      v.addr  = $urandom;
      if ($urandom_range(3, 0) != 0) v.addr[1:0] = 2'b00;
      v.wd    = $urandom;
      v.rd    = 5'($urandom);
      v.gw    = $urandom_range(gmax, 0);
      v.rw    = $urandom_range(gmax, 0);
      v.err   = ($urandom_range(4, 0) == 0);
      v.rdata = $urandom;
      model(v.op, v.addr, v.gw, v.rw, v.err, v.rdata, v.e_we, v.e_data, v.e_fault, v.e_lat);
      run_txn($sformatf("rnd%0d", i), v);
    end

    // Asynchronous reset in the middle of a bus request.
    in_valid = 1;
    params = '{rd_addr: 5'd2, mem_op: MEM_OP_LOAD, mem_data: 0, rd_data: 32'h500};
    @(posedge clk); #1;
    in_valid = 0;
    check("rst.req_before", 32'(bus.dbus_req), 32'd1);
    rst_n = 0;
    #1;
    check("rst.req", 32'(bus.dbus_req), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.addr", bus.dbus_addr, 32'd0);
    check("rst.fault_addr", fault_addr, 32'd0);
    check("rst.wb", {wb_valid, wb_we, wb_rd_addr, wb_rd_data[24:0]} | 32'(bus.dbus_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    exp_fault_addr = 0;
    v = vt[0];
    run_txn("post_rst", v);

`ifdef MEM_TIMEOUT_EN
    begin
      int lat;
      lat = -1;
      in_valid = 1;
      params = '{rd_addr: 5'd6, mem_op: MEM_OP_LOAD, mem_data: 0, rd_data: 32'h400};
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(posedge clk); #1;
        in_valid = 0;
        if (wb_valid) lat = k;
      end
      check("tmo.lat", 32'(lat), 32'd6);
      check("tmo.fault", 32'(fault), 32'd1);
      check("tmo.fault_addr", fault_addr, 32'h400);
      check("tmo.wb_we", 32'(wb_we), 32'd0);
      check("tmo.in_ready", 32'(in_ready), 32'd1);
      bus.dbus_rvalid = 1; bus.dbus_rdata = 32'hBAD;
      @(posedge clk); #1;
      bus.dbus_rvalid = 0;
      check("tmo.late_rvalid", 32'(wb_valid), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
